// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared widths, element index map and loader state encoding
//               for the 2x2 matrix operand loader / subtractor pair.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int ELEM_W   = 3;
    localparam int RES_W    = 4;
    localparam int NUM_ELEM = 8;

    // Position of each element within a frame (row-major, A then B)
    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/matrix_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_operand_loader_if
// Description : Serial element input handshake plus parallel operand output
//               handshake and status for the matrix operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_operand_loader_if #(
    parameter int ELEM_W = matrix_pkg::ELEM_W
);

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;

    logic [ELEM_W-1:0] a11;
    logic [ELEM_W-1:0] a12;
    logic [ELEM_W-1:0] a21;
    logic [ELEM_W-1:0] a22;
    logic [ELEM_W-1:0] b11;
    logic [ELEM_W-1:0] b12;
    logic [ELEM_W-1:0] b21;
    logic [ELEM_W-1:0] b22;

    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    // Stream source / operand consumer side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, a11, a12, a21, a22, b11, b12, b21, b22,
        input  out_valid, frame_err, frame_cnt
    );

    // Loader side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, a11, a12, a21, a22, b11, b12, b21, b22,
        output out_valid, frame_err, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/matrix_subtractor_2x2.sv
`default_nettype none
// ============================================================================
// Module      : matrix_subtractor_2x2
// Description : Purely combinational element-wise C = A - B on 2x2 matrices
//               of unsigned elements; results wrap modulo 2**RES_W.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_subtractor_2x2 #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int RES_W  = matrix_pkg::RES_W
) (
    input  wire logic [ELEM_W-1:0] a11,
    input  wire logic [ELEM_W-1:0] a12,
    input  wire logic [ELEM_W-1:0] a21,
    input  wire logic [ELEM_W-1:0] a22,
    input  wire logic [ELEM_W-1:0] b11,
    input  wire logic [ELEM_W-1:0] b12,
    input  wire logic [ELEM_W-1:0] b21,
    input  wire logic [ELEM_W-1:0] b22,
    output logic      [RES_W-1:0]  c11,
    output logic      [RES_W-1:0]  c12,
    output logic      [RES_W-1:0]  c21,
    output logic      [RES_W-1:0]  c22
);

    // Zero-extend before subtracting so a borrow shows up as a two's
    // complement wrap in the wider result.
    assign c11 = RES_W'(a11) - RES_W'(b11);
    assign c12 = RES_W'(a12) - RES_W'(b12);
    assign c21 = RES_W'(a21) - RES_W'(b21);
    assign c22 = RES_W'(a22) - RES_W'(b22);

endmodule
`default_nettype wire

// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_operand_loader
// Description : Collects a serial stream of 8 elements (A row-major, then B
//               row-major) into a register bank and presents them in parallel
//               under an out_valid/out_ready handshake. Checks framing with
//               in_last and counts delivered frames.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_loader #(
    parameter int ELEM_W = matrix_pkg::ELEM_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    matrix_operand_loader_if.slave bus
);

    import matrix_pkg::*;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [ELEM_W-1:0] r_elem [NUM_ELEM];
    logic              r_frame_err;
    logic              w_err_nxt;
    logic [7:0]        r_frame_cnt;
    logic              w_cnt_inc;
    logic              w_wr_en;
    logic              w_in_ready;
    logic              w_accept;

    // Ready is forced low during reset so nothing is handshaken while the
    // loader is being cleared.
    assign w_in_ready = rst_n & (r_state == LOAD);
    assign w_accept   = bus.in_valid & w_in_ready;

    // Next-state, index and status decode for the LOAD/HOLD controller
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (r_idx == IDX_B22) begin
                        // Frame is complete regardless of in_last; a missing
                        // marker is only flagged.
                        w_state_nxt = HOLD;
                        w_idx_nxt   = IDX_A11;
                        w_err_nxt   = ~bus.in_last;
                    end else if (bus.in_last) begin
                        // Early marker: drop the partial frame and restart.
                        w_idx_nxt = IDX_A11;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = LOAD;
                    w_cnt_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // Controller state, element index, error pulse and frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_idx       <= IDX_A11;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_err <= w_err_nxt;
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Element bank: the accepted element lands in the slot selected by idx
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_elem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_elem[r_idx] <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.frame_err = r_frame_err;
    assign bus.frame_cnt = r_frame_cnt;

    assign bus.a11 = r_elem[IDX_A11];
    assign bus.a12 = r_elem[IDX_A12];
    assign bus.a21 = r_elem[IDX_A21];
    assign bus.a22 = r_elem[IDX_A22];
    assign bus.b11 = r_elem[IDX_B11];
    assign bus.b12 = r_elem[IDX_B12];
    assign bus.b21 = r_elem[IDX_B21];
    assign bus.b22 = r_elem[IDX_B22];

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_operand_loader
// Description : Self-checking bench for matrix_operand_loader feeding
//               matrix_subtractor_2x2. Expected frames are queued as they are
//               sent and compared when the loader hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_operand_loader;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    matrix_operand_loader_if #(.ELEM_W(3)) bus ();

    matrix_operand_loader #(.ELEM_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] c11, c12, c21, c22;

    matrix_subtractor_2x2 #(.ELEM_W(3), .RES_W(4)) u_sub (
        .a11 (bus.a11), .a12 (bus.a12), .a21 (bus.a21), .a22 (bus.a22),
        .b11 (bus.b11), .b12 (bus.b12), .b21 (bus.b21), .b22 (bus.b22),
        .c11 (c11),     .c12 (c12),     .c21 (c21),     .c22 (c22)
    );

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          err_pulses = 0;
    int          e0;
    logic [23:0] exp_q [$];
    logic [23:0] mon_exp;
    logic [23:0] rf;
    logic [23:0] obs_frame;
    logic [15:0] obs_c;

    assign obs_frame = {bus.a11, bus.a12, bus.a21, bus.a22,
                        bus.b11, bus.b12, bus.b21, bus.b22};
    assign obs_c     = {c11, c12, c21, c22};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference subtraction: 4-bit wrap of zero-extended A minus B
    function automatic logic [15:0] sub_model(input logic [23:0] f);
        logic [15:0] r;
        logic [3:0]  a;
        logic [3:0]  b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a = {1'b0, f[23-3*i -: 3]};
            b = {1'b0, f[11-3*i -: 3]};
            r[15-4*i -: 4] = a - b;
        end
        return r;
    endfunction

    // Scoreboard: every consumed frame must match the oldest queued one
    always @(negedge clk) begin
        if (bus.frame_err) err_pulses++;
        if (bus.out_valid && bus.out_ready) begin
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("frame_data", 32'(obs_frame), 32'(mon_exp));
                check("sub_out", 32'(obs_c), 32'(sub_model(mon_exp)));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one element and wait (bounded) until the loader takes it
    task automatic send(input logic [2:0] d, input logic l);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 40) begin
                check("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] f, input bit push, input bit last8, input int max_gap);
        if (push) exp_q.push_back(f);
        for (int i = 0; i < 8; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send(f[23-3*i -: 3], (i == 7) ? last8 : 1'b0);
        end
    endtask

    // Wait (bounded) until all queued frames are consumed, then let the
    // counter update land.
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_elems", 32'(obs_frame), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame with out_ready held high
        bus.out_ready = 1'b1;
        send_frame({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0}, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_elems", 32'(obs_frame), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0}));
        check("t1_sub", 32'(obs_c), 32'h0000_CCC4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(bus.out_valid), 32'd0);
        check("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // HOLD backpressure while new data is offered
        bus.out_ready = 1'b0;
        send_frame({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b1, 1'b1, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("t2_out_valid", 32'(bus.out_valid), 32'd1);
            check("t2_elems_frozen", 32'(obs_frame),
                  32'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        check("t2_out_valid_low", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Early last on the 3rd element, then a clean frame
        e0 = err_pulses;
        send(3'd1, 1'b0);
        send(3'd2, 1'b0);
        send(3'd3, 1'b1);
        @(negedge clk);
        check("t3_err_pulse", 32'(bus.frame_err), 32'd1);
        check("t3_no_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_err_cleared", 32'(bus.frame_err), 32'd0);
        check("t3_no_valid2", 32'(bus.out_valid), 32'd0);
        check("t3_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send_frame({3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd5, 3'd3, 3'd4}, 1'b1, 1'b1, 0);
        drain();
        @(negedge clk);
        check("t3_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        check("t3_err_count", 32'(err_pulses - e0), 32'd1);
        @(posedge clk);
        #1;

        // Missing last: frame still delivered, error flagged
        e0 = err_pulses;
        send_frame({3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4}, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("t4_err_pulse", 32'(bus.frame_err), 32'd1);
        check("t4_out_valid", 32'(bus.out_valid), 32'd1);
        #1;
        drain();
        @(negedge clk);
        check("t4_frame_cnt", 32'(bus.frame_cnt), 32'd4);
        check("t4_err_count", 32'(err_pulses - e0), 32'd1);
        @(posedge clk);
        #1;

        // Random data with random gaps until the counter wraps to zero
        e0 = err_pulses;
        for (int f = 0; f < 252; f++) begin
            rf = 24'($urandom());
            send_frame(rf, 1'b1, 1'b1, 2);
        end
        drain();
        @(negedge clk);
        check("t5_cnt_wrap", 32'(bus.frame_cnt), 32'd0);
        check("t5_no_err", 32'(err_pulses - e0), 32'd0);
        @(posedge clk);
        #1;

        // Reset after 5 accepted elements
        send(3'd6, 1'b0);
        send(3'd5, 1'b0);
        send(3'd4, 1'b0);
        send(3'd3, 1'b0);
        send(3'd2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_in_ready_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("t6_frame_err", 32'(bus.frame_err), 32'd0);
        check("t6_elems", 32'(obs_frame), 32'd0);
        @(posedge clk);
        #1;
        send_frame({3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7, 3'd2}, 1'b1, 1'b1, 0);
        drain();
        @(negedge clk);
        check("t6_frame_cnt_after", 32'(bus.frame_cnt), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
